// File: rtl/maze_pkg.sv
// Shared types, constants and helpers for the maze engine.
package maze_pkg;

    localparam int unsigned MAP_DIM = 8;

    localparam logic [3:0] START_ADDR = 4'd8;
    localparam logic [3:0] END_ADDR   = 4'd9;
    localparam logic [3:0] LAST_ADDR  = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StCheck,
        StPlay,
        StWon,
        StErr
    } state_e;

    // One byte per row; map[r] is ROM address r.
    typedef logic [MAP_DIM-1:0][7:0] map_t;

    // Column 0 lives in the MSB of each row byte.
    function automatic logic [2:0] cell_bit(input logic [2:0] col);
        return 3'd7 - col;
    endfunction

    function automatic logic cell_open(input map_t map, input logic [2:0] row,
                                       input logic [2:0] col);
        return map[row][cell_bit(col)];
    endfunction

endpackage

// File: rtl/maze_move_check.sv
// Combinational move evaluation: target cell, legality, and command validity.
module maze_move_check
    import maze_pkg::*;
(
    input  logic [2:0] pos_row,
    input  logic [2:0] pos_col,
    input  logic [3:0] move,       // {up, down, left, right}
    input  map_t       map,
    output logic [2:0] tgt_row,
    output logic [2:0] tgt_col,
    output logic       legal,
    output logic       valid_cmd
);

    logic in_board;

    // Decode the move, stay on the board, then test the target cell.
    always_comb begin
        tgt_row   = pos_row;
        tgt_col   = pos_col;
        in_board  = 1'b0;
        valid_cmd = (move != 4'd0) && ((move & (move - 4'd1)) == 4'd0);
        unique case (move)
            4'b1000: begin
                in_board = (pos_row != 3'd0);
                tgt_row  = pos_row - 3'd1;
            end
            4'b0100: begin
                in_board = (pos_row != 3'd7);
                tgt_row  = pos_row + 3'd1;
            end
            4'b0010: begin
                in_board = (pos_col != 3'd0);
                tgt_col  = pos_col - 3'd1;
            end
            4'b0001: begin
                in_board = (pos_col != 3'd7);
                tgt_col  = pos_col + 3'd1;
            end
            default: in_board = 1'b0;
        endcase
        legal = valid_cmd && in_board && cell_open(map, tgt_row, tgt_col);
    end

endmodule

// File: rtl/maze_engine.sv
// Loads a maze from the map ROM, validates it, and moves the player on it.
module maze_engine
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic       rom_en,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       move_left,
    input  logic       move_right,
    output logic       ready,
    output logic       win,
    output logic       err,
    output logic       bump,
    output logic [2:0] pos_row,
    output logic [2:0] pos_col,
    input  logic [2:0] disp_row_sel,
    output logic [7:0] disp_row
);

    state_e     state_q;
    logic [3:0] cnt_q;
    map_t       map_q;
    logic [5:0] start_q;
    logic [5:0] end_q;
    logic       cap_vld_q;   // a ROM read was issued last cycle
    logic [3:0] cap_slot_q;  // address of that read

    logic [2:0] tgt_row;
    logic [2:0] tgt_col;
    logic       legal;
    logic       valid_cmd;
    logic       start_open;
    logic       end_open;

    maze_move_check u_move_check (
        .pos_row   (pos_row),
        .pos_col   (pos_col),
        .move      ({move_up, move_down, move_left, move_right}),
        .map       (map_q),
        .tgt_row   (tgt_row),
        .tgt_col   (tgt_col),
        .legal     (legal),
        .valid_cmd (valid_cmd)
    );

    // Start and end cells must both be open for the maze to be playable.
    always_comb begin
        start_open = cell_open(map_q, start_q[5:3], start_q[2:0]);
        end_open   = cell_open(map_q, end_q[5:3], end_q[2:0]);
        disp_row   = map_q[disp_row_sel];
    end

    // Capture ROM data one cycle after each issued read into the slot it was read for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
        end else begin
            cap_vld_q  <= rom_en;
            cap_slot_q <= rom_addr;
            if (cap_vld_q) begin
                if (cap_slot_q == START_ADDR) begin
                    start_q <= rom_data[5:0];
                end else if (cap_slot_q == END_ADDR) begin
                    end_q <= rom_data[5:0];
                end else if (cap_slot_q < 4'(MAP_DIM)) begin
                    map_q[cap_slot_q[2:0]] <= rom_data;
                end
            end
        end
    end

    // Main FSM with registered status outputs, ROM sequencing and player position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            ready    <= 1'b0;
            win      <= 1'b0;
            err      <= 1'b0;
            bump     <= 1'b0;
            pos_row  <= '0;
            pos_col  <= '0;
        end else begin
            bump <= 1'b0;
            if (load) begin
                // Load overrides everything, including a coincident move.
                state_q  <= StLoad;
                cnt_q    <= '0;
                rom_en   <= 1'b1;
                rom_addr <= '0;
                ready    <= 1'b0;
                win      <= 1'b0;
                err      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StLoad: begin
                        if (cnt_q == LAST_ADDR) begin
                            state_q  <= StDrain;
                            rom_en   <= 1'b0;
                            rom_addr <= '0;
                        end else begin
                            cnt_q    <= cnt_q + 4'd1;
                            rom_addr <= cnt_q + 4'd1;
                        end
                    end
                    StDrain: state_q <= StCheck;
                    StCheck: begin
                        if (!start_open || !end_open) begin
                            state_q <= StErr;
                            err     <= 1'b1;
                        end else begin
                            pos_row <= start_q[5:3];
                            pos_col <= start_q[2:0];
                            if (start_q == end_q) begin
                                state_q <= StWon;
                                win     <= 1'b1;
                            end else begin
                                state_q <= StPlay;
                                ready   <= 1'b1;
                            end
                        end
                    end
                    StPlay: begin
                        if (valid_cmd) begin
                            if (legal) begin
                                pos_row <= tgt_row;
                                pos_col <= tgt_col;
                                if ({tgt_row, tgt_col} == end_q) begin
                                    state_q <= StWon;
                                    ready   <= 1'b0;
                                    win     <= 1'b1;
                                end
                            end else begin
                                bump <= 1'b1;
                            end
                        end
                    end
                    StWon: ;
                    StErr: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/maze_engine.md
# maze_engine

Loads one maze from the synchronous map ROM and runs the player on it. On a load request it reads ROM addresses 0–9 and latches:
- the 8×8 cell map from addresses 0–7;
- the start point from address 8;
- the end point from address 9.

It then accepts single-step move pulses, rejects moves into walls or off the board, and flags arrival at the end point. It sits directly downstream of the map ROM and upstream of the display scanner and game controller.

## Interface
Parameters: none (geometry fixed at 8×8, in maze_pkg).
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- load  in  1  1-cycle pulse: (re)load maze from ROM; honoured in every state
- rom_en  out  1  ROM read enable
- rom_addr  out  4  ROM address
- rom_data  in  8  ROM output; valid the cycle after rom_en/rom_addr sampled
- move_up, move_down, move_left, move_right  in  1 each  1-cycle move pulses
- ready  out  1  in PLAY state, moves accepted
- win  out  1  player on end cell (WON state)
- err  out  1  loaded maze invalid (ERR state)
- bump  out  1  1-cycle pulse: legal-looking move rejected (wall/edge)
- pos_row, pos_col  out  3 each  player position
- disp_row_sel  in  3  display row select
- disp_row  out  8  combinational map row disp_row_sel, same bit order as ROM

## Operation
- **Map convention:**
  - row r = ROM address r.
  - column c = data bit [7−c] (MSB is column 0).
  - 1 = open, 0 = wall.
  - Start/end byte: row = [5:3], col = [2:0]; bits [7:6] ignored.
- **States and transitions:**
  - **IDLE:** load → LOAD.
  - **LOAD:** cnt runs 0..9; rom_en=1, rom_addr=cnt. After cnt=9 → DRAIN.
  - **DRAIN:** rom_en=0; captures the final byte. → CHECK.
  - **CHECK:** validates start and end cells.
    - Either cell closed → ERR.
    - Otherwise pos ← start, then start==end → WON, else → PLAY.
  - **PLAY:** ready=1; processes moves.
  - **WON:** win=1.
  - **ERR:** err=1.
  - load in any state → LOAD with cnt=0. Restarting mid-load discards partial data; map rows are overwritten as recaptured.
- **Capture:** rom_data is written to slot cnt_d, which is cnt delayed one cycle, on every cycle after an issued read (LOAD cycles 2..10, DRAIN).
- **Moves, PLAY only:**
  - Exactly one move_* high → target = pos ±1 on one axis.
  - Target off-board (row/col <0 or >7) or a wall cell → bump=1 next cycle, pos unchanged.
  - Otherwise pos ← target. If target == end → WON.
  - Zero or ≥2 move_* high → no action, no bump.
- **Moves ignored** in IDLE/LOAD/DRAIN/CHECK/WON/ERR (no bump).
- **load with a simultaneous move:** load wins; the move is dropped.
- **Reset:** state IDLE; map, start, end, pos cleared to 0; all outputs 0 (rom_en, rom_addr, ready, win, err, bump, pos_*). disp_row reflects the cleared map (0).

## Timing
Let edge E0 be the edge that samples load.
- rom_addr=0..9 is driven during the cycles after E0..E9.
- ROM data for address 9 is valid after E10 and captured at E11.
- CHECK is evaluated at E12; ready, win or err is high after E12. Load-to-ready latency is 12 cycles.
- **Move accepted at edge Em:**
  - pos updates after Em.
  - win rises after Em if the end is reached.
  - bump is high for exactly the cycle after Em.
- One move per cycle. Back-to-back pulses are each evaluated against the updated pos.
- disp_row is combinational from the map registers; there is no pipeline.

## Structure
- **maze_pkg** contains:
  - state enum;
  - START_ADDR=4'd8, END_ADDR=4'd9, LAST_ADDR=4'd9;
  - MAP_DIM=8;
  - a cell-bit index function (7−col).
- **Sub-module maze_move_check** (combinational):
  - inputs: pos, one-hot move vector, map;
  - outputs: target, legal, valid_cmd.
- **maze_engine:** FSM, load counter, map/start/end registers, position register.

## Test plan
Bench ROM model: a registered, enable-gated model holding rows 0F, FC, 27, EA, 8E, 92, B6, E4; start 0x18; end 0x3D.
- **Load:** reset, pulse load → rom_addr sweeps 0..9 over 10 cycles; ready=1 exactly 12 edges after load; pos=(3,0); disp_row_sel=4 gives 8E.
- **Rejected moves:** from (3,0), move_left → bump pulse, pos (3,0). move_up (row 2 col 0 is a wall) → bump, pos (3,0).
- **Winning path:** R,R,U,U,R,R,R,D,R,D,D,D,D,L,D → reaches (7,5); win=1, ready=0. A further move_down → no change, no bump.
- **Illegal command:** move_up and move_right in the same cycle → pos unchanged, bump=0.
- **Invalid maze:** ROM start byte 0x1B (row 3 col 3 = wall) → err=1 after E12, ready=0. Another load with start 0x18 → PLAY.
- **Restart and reset:** load pulse at the 5th LOAD cycle → sweep restarts at addr 0 and ready is 12 edges after the second pulse. Async rst asserted mid-PLAY → all outputs 0 immediately, state IDLE.
